// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared datapath constants for the pipeline slices: the machine
//            word width and the operand-forwarding select encodings.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int WORD_W  = 32;

  // Forwarding sources, driven onto a mux_pipe_reg sel port by the ID/EX stage
  localparam int NUM_FWD = 4;
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_IMM   = 2'd3;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mux_n_one.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_one
// Purpose  : Purely combinational N:1 word selector. Input k lives at
//            in_bus[k*WIDTH +: WIDTH]. An out-of-range select yields a zero
//            word and raises the illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
module mux_n_one #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]        out_word,
  output logic                    illegal
);

  // One extra bit so NUM_IN is representable even when it is a power of two
  localparam logic [SEL_W:0] c_num_in = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0] w_words [NUM_IN];

  generate
    for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
      assign w_words[k] = in_bus[k*WIDTH +: WIDTH];
    end
  endgenerate

  // Select the addressed word; no input matches an illegal select, so the
  // default zero falls through
  always_comb begin
    out_word = '0;
    illegal  = ({1'b0, sel} >= c_num_in);
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out_word = w_words[k];
      end
    end
  end

endmodule : mux_n_one
`default_nettype wire

// File: rtl/mux_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pipe_reg
// Purpose  : Operand-select plus pipeline register between ID/EX and EX/MEM.
//            Selects one of NUM_IN words and registers it together with valid,
//            the select used and an illegal-select flag. Edge priority is
//            flush > stall > load. A saturating counter tracks stall cycles
//            that held a valid word.
// Revision : 1.0 - initial release
// ============================================================================
module mux_pipe_reg
  import mips_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int NUM_IN = NUM_FWD,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    cnt_clr,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_mux_word;
  logic             w_mux_illegal;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SEL_W-1:0] r_sel;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  mux_n_one #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .sel      (sel),
    .in_bus   (in_bus),
    .out_word (w_mux_word),
    .illegal  (w_mux_illegal)
  );

  // Pipeline register: flush inserts a bubble, stall holds, otherwise load.
  // Data is loaded regardless of in_valid; consumers qualify with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_err   <= 1'b0;
    end else if (!stall) begin
      r_data  <= w_mux_word;
      r_valid <= in_valid;
      r_sel   <= sel;
      r_err   <= w_mux_illegal;
    end
  end

  // Saturating count of stalls that actually held a valid word; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (stall && !flush && r_valid && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;
  assign sel_err   = r_err;
  assign stall_cnt = r_cnt;

endmodule : mux_pipe_reg
`default_nettype wire

// File: tb/tb_mux_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_pipe_reg
// Purpose  : Self-checking bench for mux_pipe_reg. Three instances:
//            A = default (32b, 4 inputs, 8b counter),
//            B = 16b, 3 inputs, 4b counter (illegal select, saturation),
//            C = 16b, 5 inputs, 5b counter (randomised against a model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_pipe_reg;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic [1:0]   a_sel;
  logic [127:0] a_bus;
  logic         a_iv, a_st, a_fl, a_clr;
  logic [31:0]  a_data;
  logic         a_ov, a_err;
  logic [1:0]   a_osel;
  logic [7:0]   a_cnt;

  mux_pipe_reg u_a (
    .clk(clk), .rst_n(rst_n), .sel(a_sel), .in_bus(a_bus), .in_valid(a_iv),
    .stall(a_st), .flush(a_fl), .cnt_clr(a_clr), .out_data(a_data),
    .out_valid(a_ov), .out_sel(a_osel), .sel_err(a_err), .stall_cnt(a_cnt)
  );

  // ---------------- instance B ----------------
  logic [1:0]  b_sel;
  logic [47:0] b_bus;
  logic        b_iv, b_st, b_fl, b_clr;
  logic [15:0] b_data;
  logic        b_ov, b_err;
  logic [1:0]  b_osel;
  logic [3:0]  b_cnt;

  mux_pipe_reg #(.WIDTH(16), .NUM_IN(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .sel(b_sel), .in_bus(b_bus), .in_valid(b_iv),
    .stall(b_st), .flush(b_fl), .cnt_clr(b_clr), .out_data(b_data),
    .out_valid(b_ov), .out_sel(b_osel), .sel_err(b_err), .stall_cnt(b_cnt)
  );

  // ---------------- instance C ----------------
  logic [2:0]  c_sel;
  logic [79:0] c_bus;
  logic        c_iv, c_st, c_fl, c_clr;
  logic [15:0] c_data;
  logic        c_ov, c_err;
  logic [2:0]  c_osel;
  logic [4:0]  c_cnt;

  mux_pipe_reg #(.WIDTH(16), .NUM_IN(5), .CNT_W(5)) u_c (
    .clk(clk), .rst_n(rst_n), .sel(c_sel), .in_bus(c_bus), .in_valid(c_iv),
    .stall(c_st), .flush(c_fl), .cnt_clr(c_clr), .out_data(c_data),
    .out_valid(c_ov), .out_sel(c_osel), .sel_err(c_err), .stall_cnt(c_cnt)
  );

  // Advance one active edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_sel = '0; a_bus = '0; a_iv = 0; a_st = 0; a_fl = 0; a_clr = 0;
    b_sel = '0; b_bus = '0; b_iv = 0; b_st = 0; b_fl = 0; b_clr = 0;
    c_sel = '0; c_bus = '0; c_iv = 0; c_st = 0; c_fl = 0; c_clr = 0;
    #12;
    checks++;
    if ({a_data, a_ov, a_osel, a_err, a_cnt} !== 44'd0) begin
      failures++;
      $display("FAIL reset_state_a: got data=%h v=%b sel=%0d err=%b cnt=%0d, want all 0",
               a_data, a_ov, a_osel, a_err, a_cnt);
    end
    checks++;
    if ({b_data, b_ov, b_osel, b_err, b_cnt} !== 24'd0) begin
      failures++;
      $display("FAIL reset_state_b: got data=%h v=%b err=%b cnt=%0d, want all 0",
               b_data, b_ov, b_err, b_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_async_reset();
    a_bus = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    a_sel = 2'd2; a_iv = 1'b1;
    tick();
    checks++;
    if ({a_data, a_ov, a_osel} !== {32'h33333333, 1'b1, 2'd2}) begin
      failures++;
      $display("FAIL load_sel2: got data=%h v=%b sel=%0d, want 33333333 1 2",
               a_data, a_ov, a_osel);
    end
    // Reset between edges must clear outputs without waiting for a clock
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_data, a_ov, a_osel, a_err, a_cnt} !== 44'd0) begin
      failures++;
      $display("FAIL async_reset: got data=%h v=%b sel=%0d err=%b cnt=%0d, want all 0",
               a_data, a_ov, a_osel, a_err, a_cnt);
    end
    #1 rst_n = 1'b1;
    a_sel = 2'd0;
    tick();
    checks++;
    if ({a_data, a_ov, a_osel} !== {32'h11111111, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL load_after_reset: got data=%h v=%b sel=%0d, want 11111111 1 0",
               a_data, a_ov, a_osel);
    end
  endtask

  task automatic test_stall_hold();
    a_sel = 2'd1;
    tick();
    a_st = 1'b1; a_sel = 2'd3;
    repeat (3) tick();
    checks++;
    if ({a_data, a_ov, a_osel, a_cnt} !== {32'h22222222, 1'b1, 2'd1, 8'd3}) begin
      failures++;
      $display("FAIL stall_hold: got data=%h v=%b sel=%0d cnt=%0d, want 22222222 1 1 3",
               a_data, a_ov, a_osel, a_cnt);
    end
    a_st = 1'b0;
    tick();
    checks++;
    if ({a_data, a_osel, a_cnt} !== {32'h44444444, 2'd3, 8'd3}) begin
      failures++;
      $display("FAIL stall_release: got data=%h sel=%0d cnt=%0d, want 44444444 3 3",
               a_data, a_osel, a_cnt);
    end
  endtask

  task automatic test_flush_over_stall();
    a_st = 1'b1; a_fl = 1'b1;
    tick();
    checks++;
    if ({a_data, a_ov, a_osel, a_cnt} !== {32'h0, 1'b0, 2'd0, 8'd3}) begin
      failures++;
      $display("FAIL flush_over_stall: got data=%h v=%b sel=%0d cnt=%0d, want 0 0 0 3",
               a_data, a_ov, a_osel, a_cnt);
    end
    // Stall with an empty register must not count
    a_fl = 1'b0;
    tick();
    checks++;
    if ({a_ov, a_cnt} !== {1'b0, 8'd3}) begin
      failures++;
      $display("FAIL stall_invalid_nocount: got v=%b cnt=%0d, want 0 3", a_ov, a_cnt);
    end
    a_st = 1'b0;
  endtask

  task automatic test_illegal_sel();
    b_bus = {16'h3333, 16'h2222, 16'h1111};
    b_sel = 2'd3; b_iv = 1'b1;
    tick();
    checks++;
    if ({b_data, b_err, b_ov, b_osel} !== {16'h0, 1'b1, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL illegal_load: got data=%h err=%b v=%b sel=%0d, want 0 1 1 3",
               b_data, b_err, b_ov, b_osel);
    end
    b_st = 1'b1; b_sel = 2'd0;
    tick();
    checks++;
    if (b_err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_sticky_stall: got err=%b, want 1", b_err);
    end
    b_st = 1'b0;
    tick();
    checks++;
    if ({b_data, b_err} !== {16'h1111, 1'b0}) begin
      failures++;
      $display("FAIL illegal_cleared_by_load: got data=%h err=%b, want 1111 0", b_data, b_err);
    end
    b_sel = 2'd3;
    tick();
    b_fl = 1'b1;
    tick();
    checks++;
    if ({b_err, b_ov} !== 2'b00) begin
      failures++;
      $display("FAIL illegal_cleared_by_flush: got err=%b v=%b, want 0 0", b_err, b_ov);
    end
    b_fl = 1'b0;
  endtask

  task automatic test_cnt_saturate_clear();
    b_sel = 2'd1; b_iv = 1'b1; b_clr = 1'b1;
    tick();
    b_clr = 1'b0; b_st = 1'b1;
    repeat (20) tick();
    checks++;
    if ({b_cnt, b_data} !== {4'd15, 16'h2222}) begin
      failures++;
      $display("FAIL cnt_saturate: got cnt=%0d data=%h, want 15 2222", b_cnt, b_data);
    end
    b_clr = 1'b1;
    tick();
    checks++;
    if (b_cnt !== 4'd0) begin
      failures++;
      $display("FAIL cnt_clear_over_stall: got cnt=%0d, want 0", b_cnt);
    end
    b_clr = 1'b0;
    tick();
    checks++;
    if (b_cnt !== 4'd1) begin
      failures++;
      $display("FAIL cnt_after_clear: got cnt=%0d, want 1", b_cnt);
    end
    b_st = 1'b0;
  endtask

  // Randomised run of instance C against a cycle-level model of the register
  task automatic test_random();
    logic [15:0] words [5];
    logic [15:0] m_data = '0;
    logic        m_valid = 1'b0;
    int          m_sel = 0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;
    logic [25:0] got, want;
    c_fl = 1'b1; c_clr = 1'b1;
    tick();
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 5; k++) words[k] = 16'($urandom);
      c_bus = {words[4], words[3], words[2], words[1], words[0]};
      c_sel = 3'($urandom_range(0, 7));
      c_iv  = 1'($urandom);
      c_st  = ($urandom_range(0, 99) < 35);
      c_fl  = ($urandom_range(0, 99) < 8);
      c_clr = ($urandom_range(0, 99) < 2);
      // Counter uses the valid flag held before this edge
      if (c_clr)                                  m_cnt = 0;
      else if (c_st && !c_fl && m_valid && m_cnt < 31) m_cnt = m_cnt + 1;
      if (c_fl) begin
        m_valid = 1'b0; m_sel = 0; m_err = 1'b0; m_data = '0;
      end else if (!c_st) begin
        m_valid = c_iv;
        m_sel   = int'(c_sel);
        m_err   = (m_sel >= 5);
        m_data  = m_err ? 16'h0 : words[m_sel];
      end
      tick();
      got  = {c_ov, c_osel, c_err, c_cnt, (c_ov ? c_data : 16'h0)};
      want = {m_valid, 3'(m_sel), m_err, 5'(m_cnt), (m_valid ? m_data : 16'h0)};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random_cycle_%0d: got {v,sel,err,cnt,data}=%h, want %h", n, got, want);
      end
    end
    c_st = 1'b0; c_fl = 1'b0; c_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_async_reset();
    test_stall_hold();
    test_flush_over_stall();
    test_illegal_sel();
    test_cnt_saturate_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_pipe_reg
`default_nettype wire

// File: doc/mux_pipe_reg.md
Name: mux_pipe_reg

Overview:
Parametrised N:1 word selector with a registered output stage, used as the operand-select plus pipeline-register slice between ID/EX and EX/MEM.
Generalises the 2:1 combinational word mux in width and input count.
Adds stall (hold), flush (bubble insertion), valid tracking, illegal-select detection and a saturating stall counter for performance monitoring.

Parameters:
WIDTH, 32, data word width in bits.
NUM_IN, 4, number of selectable inputs; legal range 2..16.
SEL_W, $clog2(NUM_IN) (2), select width; derived, never overridden.
CNT_W, 8, stall counter width.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
sel  input  SEL_W  source select; input k occupies in_bus[k*WIDTH +: WIDTH].
in_bus  input  NUM_IN*WIDTH  concatenated candidate words.
in_valid  input  1  the current upstream word is a real instruction.
stall  input  1  hold the register contents this cycle.
flush  input  1  insert a bubble this cycle.
out_data  output  WIDTH  registered selected word.
out_valid  output  1  registered valid.
out_sel  output  SEL_W  registered copy of the sel that produced out_data.
sel_err  output  1  registered flag: the last load used sel >= NUM_IN.
stall_cnt  output  CNT_W  saturating count of stall cycles with out_valid=1.
cnt_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): out_data=0, out_valid=0, out_sel=0, sel_err=0, stall_cnt=0.
- Latency: exactly 1 cycle from sel/in_bus/in_valid to the outputs when loading.
- Per-edge priority: flush > stall > load.
- Flush: out_valid=0, out_data=0, out_sel=0, sel_err=0. Flush overrides a simultaneous stall.
- Stall (no flush): out_data, out_valid, out_sel and sel_err all hold.
- Load (neither flush nor stall): out_data=in_bus[sel], out_valid=in_valid, out_sel=sel.
- Illegal select (sel >= NUM_IN; only possible when NUM_IN is not a power of two):
  - A load gives out_data=0 and sel_err=1.
  - out_valid still follows in_valid.
  - sel_err stays 1 until the next load with a legal sel, a flush, or reset.
- Data is loaded even when in_valid=0, so out_data is don't-care when out_valid=0. The bench checks out_data only when out_valid=1.
- stall_cnt:
  - Increments by 1 on each edge where stall=1, flush=0 and out_valid=1 (a stall with nothing valid in the register is not counted).
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr=1 forces 0 at the next edge and has priority over an increment.
  - Flush does not affect the counter.
- No state machine beyond the register. The stall/flush/load state space is fully enumerated above.
- Reset asserted mid-stall clears everything. After rst_n rises, the first edge with stall=0 and flush=0 loads normally.
- No combinational path from any input to any output.

Decomposition:
- Shared package mips_pkg holds:
  - WORD_W=32.
  - Forwarding select encodings FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2, FWD_IMM=3.
  - NUM_FWD=4.
- Instantiating stages drive sel with these constants.
- One natural sub-module: mux_n_one, a purely combinational N:1 WIDTH-bit mux (parameters WIDTH, NUM_IN). It outputs 0 for an illegal select and exposes an illegal flag. It directly generalises the existing 2:1 word mux.
- mux_pipe_reg instantiates mux_n_one and wraps it with the register, priority logic and counter.

Test Plan:
- Reset then load: in_bus words 0x11111111, 0x22222222, 0x33333333, 0x44444444 (inputs 0..3), sel=2, in_valid=1, no stall/flush -> after 1 edge out_data=0x33333333, out_valid=1, out_sel=2. Then assert rst_n=0 between edges -> all outputs 0 immediately.
- Stall hold: load sel=1 (0x22222222), then stall=1 for 3 edges while sel=3 -> out_data stays 0x22222222, stall_cnt=3. Release -> next edge out_data=0x44444444.
- Flush over stall: out_valid=1, assert stall=1 and flush=1 together -> next edge out_valid=0, out_data=0, stall_cnt unchanged.
- Illegal select with NUM_IN=3: sel=3, in_valid=1 -> out_data=0, sel_err=1, out_valid=1. Next load sel=0 -> sel_err=0, out_data=in_bus[0].
- Counter saturation/clear with CNT_W=4 and out_valid=1: 20 stall cycles -> stall_cnt=15. cnt_clr=1 concurrent with stall -> stall_cnt=0.
- Random sel/in_valid/stall/flush for 10k cycles with NUM_IN=5, WIDTH=16 against a reference model -> zero mismatches.
